// File: rtl/inst_loader_pkg.sv
// Shared definitions for the instruction loader: default geometry and the
// loader state encoding.
package inst_loader_pkg;

    localparam int DEF_WORD = 32;   // instruction width, multiple of 8
    localparam int DEF_ADDR = 8;    // instruction-memory address width

    typedef enum logic [2:0] {
        LD_LEN_LO = 3'd0,
        LD_LEN_HI = 3'd1,
        LD_DATA   = 3'd2,
        LD_WRITE  = 3'd3,
        LD_DONE   = 3'd4,
        LD_ERR    = 3'd5
    } ld_state_e;

endpackage

// File: rtl/inst_loader_word_packer.sv
// Packs a little-endian byte stream into WORD-bit words. Byte k of a word
// lands in bits [8k+7:8k]. word_valid flags the byte that completes a word,
// so the assembled value is present on word from the following cycle on.
module word_packer #(
    parameter int WORD = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [7:0]      byte_in,
    input  logic            byte_en,
    output logic            word_valid,
    output logic [WORD-1:0] word
);

    localparam int BYTES = WORD / 8;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [CNT_W-1:0] cnt;
    logic             last_byte;

    assign last_byte  = (cnt == CNT_W'(BYTES - 1));
    assign word_valid = byte_en && last_byte;

    // Byte counter wraps 0..BYTES-1; each accepted byte is dropped into its lane.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            word <= '0;
        end else if (byte_en) begin
            word[8*cnt +: 8] <= byte_in;
            cnt              <= last_byte ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/inst_loader.sv
// Writer end of the instruction-memory port. Consumes a byte stream
// (2-byte LE word count N, then N LE words), writes the words to
// consecutive addresses, and holds the core stalled until the load is done.
//
// state     | meaning
// ----------+------------------------------------------------------------
// LD_LEN_LO | waiting for low byte of word count
// LD_LEN_HI | waiting for high byte of word count; decides DONE/ERR/DATA
// LD_DATA   | collecting bytes of the current word
// LD_WRITE  | one-cycle memory write of the assembled word at idx
// LD_DONE   | load finished; address port handed back to the core
// LD_ERR    | word count exceeded memory depth; waits for start_i
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int WORD = DEF_WORD,
    parameter int ADDR = DEF_ADDR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic [7:0]      byte_i,
    input  logic            byte_valid_i,
    output logic            byte_ready_o,
    input  logic [ADDR-1:0] core_addr_i,
    output logic [ADDR-1:0] mem_addr_o,
    output logic            mem_write_o,
    output logic [WORD-1:0] mem_data_o,
    output logic            core_stall_o,
    output logic            done_o,
    output logic            err_o
);

    localparam logic [31:0] DEPTH = 32'(1) << ADDR;

    ld_state_e   state, state_nxt;
    logic [ADDR:0] idx;          // one extra bit so N == DEPTH is reachable
    logic [15:0] n_words;
    logic [15:0] n_full;
    logic        accept;
    logic        pack_en;
    logic        word_valid;
    logic        last_word;

    assign byte_ready_o = (state == LD_LEN_LO) || (state == LD_LEN_HI) || (state == LD_DATA);
    assign accept       = byte_valid_i && byte_ready_o;
    assign pack_en      = accept && (state == LD_DATA);
    assign n_full       = {byte_i, n_words[7:0]};
    assign last_word    = ((32'(idx) + 32'd1) == 32'(n_words));

    word_packer #(.WORD(WORD)) u_packer (
        .clk        (clk),
        .reset      (reset),
        .byte_in    (byte_i),
        .byte_en    (pack_en),
        .word_valid (word_valid),
        .word       (mem_data_o)
    );

    // Next-state decode for the load sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            LD_LEN_LO: if (accept) state_nxt = LD_LEN_HI;
            LD_LEN_HI: begin
                if (accept) begin
                    if (n_full == 16'd0)
                        state_nxt = LD_DONE;
                    else if (32'(n_full) > DEPTH)
                        state_nxt = LD_ERR;
                    else
                        state_nxt = LD_DATA;
                end
            end
            LD_DATA:   if (word_valid) state_nxt = LD_WRITE;
            LD_WRITE:  state_nxt = last_word ? LD_DONE : LD_DATA;
            LD_DONE,
            LD_ERR:    if (start_i) state_nxt = LD_LEN_LO;
            default:   state_nxt = LD_LEN_LO;
        endcase
    end

    // State register plus word count capture and write index bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= LD_LEN_LO;
            idx     <= '0;
            n_words <= '0;
        end else begin
            state <= state_nxt;
            if (state == LD_LEN_LO && accept)
                n_words[7:0] <= byte_i;
            if (state == LD_LEN_HI && accept)
                n_words[15:8] <= byte_i;
            if (state == LD_WRITE)
                idx <= idx + 1'b1;
            else if ((state == LD_DONE || state == LD_ERR) && start_i)
                idx <= '0;
        end
    end

    assign mem_write_o  = (state == LD_WRITE);
    assign mem_addr_o   = (state == LD_DONE) ? core_addr_i : idx[ADDR-1:0];
    assign core_stall_o = (state != LD_DONE);
    assign done_o       = (state == LD_DONE);
    assign err_o        = (state == LD_ERR);

endmodule
